// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 16x-oversampled 8N1 UART receiver; rx in, rx_data/rx_done_tick/framing_error/busy out
module uart_rx_byte #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk_100MHz,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done_tick,
  output logic                 framing_error,
  output logic                 busy
);
  localparam int DIVISOR = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW = DIVISOR > 1 ? $clog2(DIVISOR) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, rx_prev, tick;
  logic [DW-1:0] tick_cnt;
  logic [3:0] s_cnt, s_cnt_n;
  logic [BW-1:0] b_cnt, b_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic done_n, ferr_n;
  assign tick = tick_cnt == DW'(DIVISOR - 1);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    b_cnt_n = b_cnt;
    shreg_n = shreg;
    data_n  = rx_data;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE:
        if (rx_prev && !rx_s) begin
          s_cnt_n = 4'd0;
          state_n = START;
        end
      START:
        if (tick) begin
          if (s_cnt == 4'd7) begin
            s_cnt_n = 4'd0;
            b_cnt_n = '0;
            state_n = rx_s ? IDLE : DATA;
          end else s_cnt_n = s_cnt + 4'd1;
        end
      DATA:
        if (tick) begin
          if (s_cnt == 4'd15) begin
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            s_cnt_n = 4'd0;
            b_cnt_n = b_cnt + BW'(1);
            state_n = b_cnt == BW'(DATA_BITS - 1) ? STOP : DATA;
          end else s_cnt_n = s_cnt + 4'd1;
        end
      default:
        if (tick) begin
          if (s_cnt == 4'd15) begin
            data_n  = rx_s ? shreg : rx_data;
            done_n  = rx_s;
            ferr_n  = !rx_s;
            state_n = IDLE;
          end else s_cnt_n = s_cnt + 4'd1;
        end
    endcase
  end
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      rx_prev       <= 1'b1;
      tick_cnt      <= '0;
      state         <= IDLE;
      s_cnt         <= 4'd0;
      b_cnt         <= '0;
      shreg         <= '0;
      rx_data       <= '0;
      rx_done_tick  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_m          <= rx;
      rx_s          <= rx_m;
      rx_prev       <= rx_s;
      tick_cnt      <= tick ? '0 : tick_cnt + DW'(1);
      state         <= state_n;
      s_cnt         <= s_cnt_n;
      b_cnt         <= b_cnt_n;
      shreg         <= shreg_n;
      rx_data       <= data_n;
      rx_done_tick  <= done_n;
      framing_error <= ferr_n;
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: randomized frame stimulus checked against a frame-level expectation queue
module tb_uart_rx_byte;
  localparam int BAUD = 9600;
  localparam int CLK_FREQ = BAUD * 16 * 4;
  localparam int BIT = 64;
  localparam int LAT_MIN = BIT * 19 / 2 - 2;
  localparam int LAT_MAX = BIT * 19 / 2 + 3 + 4 + 1;
  logic clk_100MHz = 1'b0, reset_n = 1'b0, rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_done_tick, framing_error, busy;
  typedef struct {logic bad; logic [7:0] d; int st;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0;
  int done_cnt = 0, ferr_cnt = 0, exp_done = 0, exp_ferr = 0;
  logic [7:0] model_data = 8'h00;
  logic prev_pulse = 1'b0;
  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .rx(rx), .rx_data(rx_data),
    .rx_done_tick(rx_done_tick), .framing_error(framing_error), .busy(busy));
  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) cyc <= cyc + 1;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk_100MHz) begin
    if (!reset_n) begin
      prev_pulse = 1'b0;
      model_data = 8'h00;
    end else begin
      if (rx_done_tick || framing_error) begin
        exp_t e;
        int lat;
        chk("exclusive", {31'd0, rx_done_tick && framing_error}, 0);
        chk("back_to_back_pulse", {31'd0, prev_pulse}, 0);
        chk("expected_frame", {31'd0, q.size() != 0}, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          lat = cyc - e.st;
          chk("pulse_kind", {31'd0, framing_error}, {31'd0, e.bad});
          chk("latency_window", {31'd0, lat >= LAT_MIN && lat <= LAT_MAX}, 1);
          if (!e.bad) begin
            chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
            model_data = e.d;
          end else chk("rx_data_hold", {24'd0, rx_data}, {24'd0, model_data});
        end
        if (rx_done_tick) done_cnt++;
        else ferr_cnt++;
      end
      prev_pulse = rx_done_tick || framing_error;
    end
  end
  task automatic send(logic [7:0] d, bit good, int gap);
    exp_t e;
    e.bad = !good;
    e.d = d;
    e.st = cyc;
    q.push_back(e);
    if (good) exp_done++;
    else exp_ferr++;
    rx = 1'b0;
    repeat (BIT) @(negedge clk_100MHz);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk_100MHz);
    end
    rx = good;
    repeat (BIT) @(negedge clk_100MHz);
    rx = 1'b1;
    repeat (gap * BIT) @(negedge clk_100MHz);
  endtask
  task automatic settle(string tag);
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk_100MHz);
    repeat (BIT) @(negedge clk_100MHz);
    chk({tag, "_drained"}, q.size(), 0);
    chk({tag, "_ndone"}, done_cnt, exp_done);
    chk({tag, "_nferr"}, ferr_cnt, exp_ferr);
  endtask
  initial begin
    repeat (100) @(negedge clk_100MHz);
    chk("rst_rx_data", {24'd0, rx_data}, 0);
    chk("rst_done", {31'd0, rx_done_tick}, 0);
    chk("rst_ferr", {31'd0, framing_error}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_100MHz);
    chk("idle_busy", {31'd0, busy}, 0);
    send(8'h41, 1'b1, 1);
    settle("char_A");
    chk("rx_data_A", {24'd0, rx_data}, 32'h41);
    send(8'h53, 1'b1, 0);
    send(8'h49, 1'b1, 0);
    send(8'h4D, 1'b1, 1);
    settle("b2b");
    send(8'hA5, 1'b0, 2);
    settle("ferr");
    chk("ferr_hold", {24'd0, rx_data}, 32'h4D);
    rx = 1'b0;
    repeat (6) @(negedge clk_100MHz);
    chk("glitch_busy", {31'd0, busy}, 1);
    repeat (6) @(negedge clk_100MHz);
    rx = 1'b1;
    repeat (50) @(negedge clk_100MHz);
    chk("glitch_idle", {31'd0, busy}, 0);
    settle("glitch");
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      bit good;
      d = 8'($urandom);
      good = $urandom_range(0, 4) != 0;
      send(d, good, good ? $urandom_range(0, 2) : $urandom_range(1, 2));
    end
    settle("random");
    rx = 1'b0;
    repeat (BIT) @(negedge clk_100MHz);
    for (int i = 0; i < 4; i++) begin
      rx = i[0] ? 1'b1 : 1'b0;
      rx = 8'h3C >> i;
      repeat (BIT) @(negedge clk_100MHz);
    end
    rx = 1'b1;
    repeat (BIT / 2) @(negedge clk_100MHz);
    reset_n = 1'b0;
    repeat (5) @(negedge clk_100MHz);
    chk("midrst_rx_data", {24'd0, rx_data}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_100MHz);
    send(8'h7E, 1'b1, 1);
    settle("after_rst");
    chk("rx_data_7E", {24'd0, rx_data}, 32'h7E);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
